irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that sits directly upstream of the multi-cycle CPU's `Ireq`/`Iack` pins. It replaces the single-button request flop in the SoC top level. It collects up to `N_SRC` asynchronous sources (debounced buttons, `Counter_x` outputs, future UART) and synchronizes them. It latches edges into a pending register, applies a mask and a fixed priority, and drives one `Ireq` with a vector the CPU reads over the MIO bus. It sits on the MIO bus beside `led_Dev_IO` and `seven_seg_Dev_IO`, clocked by `clk_io`.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_if.sv | 26 ++
 rtl/irq_sync_edge.sv | 34 +++
 rtl/irq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// state encoding and CTRL register field positions.
package irq_pkg;

    localparam int unsigned REG_W = 32;

    // Word offsets on the MIO register port
    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_MODE = 2'd2;
    localparam logic [1:0] IRQ_CTRL = 2'd3;

    // FSM encoding, also visible in CTRL[30:29]
    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_REQ  = 2'b01,
        IRQ_SVC  = 2'b10
    } irq_state_e;

    // CTRL field positions
    localparam int unsigned CTRL_EOI_BIT   = 0;
    localparam int unsigned CTRL_STATE_LSB = 29;
    localparam int unsigned CTRL_STATE_W   = 2;
    localparam int unsigned CTRL_IREQ_BIT  = 31;

endpackage

// File: rtl/irq_if.sv
// MIO register port plus CPU request/acknowledge handshake.
//   slave  : controller side (irq_ctrl)
//   master : bus decode / CPU side
// Signals: reg_we_i, reg_addr_i[1:0], reg_wdata_i[31:0], reg_rdata_o[31:0],
//          Ireq, Iack, irq_id_o[ID_W-1:0]
interface irq_if #(
    parameter int unsigned ID_W = 4
);
    logic            reg_we_i;
    logic [1:0]      reg_addr_i;
    logic [31:0]     reg_wdata_i;
    logic [31:0]     reg_rdata_o;
    logic            Ireq;
    logic            Iack;
    logic [ID_W-1:0] irq_id_o;

    modport slave (
        input  reg_we_i, reg_addr_i, reg_wdata_i, Iack,
        output reg_rdata_o, Ireq, irq_id_o
    );

    modport master (
        output reg_we_i, reg_addr_i, reg_wdata_i, Iack,
        input  reg_rdata_o, Ireq, irq_id_o
    );
endinterface

// File: rtl/irq_sync_edge.sv
// Single-bit 2-flop synchronizer followed by a rising-edge detector.
//   clk, rst : clock, synchronous active-low reset
//   src      : asynchronous input
//   level    : synchronized level (s2)
//   rise     : one-cycle pulse when s2 goes 0->1
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    // Synchronizer chain plus delay flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller in front of the CPU Ireq/Iack pins.
// Synchronizes N_SRC sources, latches edges (or follows levels) into PEND,
// masks, priority-encodes (lowest index wins) and runs IDLE/REQ/SERVICE.
//   clk, rst   : clock, synchronous active-low reset
//   irq_src_i  : raw asynchronous sources
//   bus        : register port (PEND/MASK/MODE/CTRL) and Ireq/Iack/irq_id_o
module irq_ctrl #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src_i,
    irq_if.slave             bus
);
    import irq_pkg::*;

    logic [N_SRC-1:0] lvl;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] wdata_src;

    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  id_d;
    logic [ID_W-1:0]  sel_id;
    logic             ireq_q;
    logic             ack_take;

    logic             wr_pend;
    logic             wr_mask;
    logic             wr_mode;
    logic             eoi;
    logic [REG_W-1:0] rdata;
    logic             unused_wdata;

    // Per-source synchronizer and edge detector
    for (genvar g = 0; g < int'(N_SRC); g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .src   (irq_src_i[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    // Register write decode
    assign wdata_src    = bus.reg_wdata_i[N_SRC-1:0];
    assign wr_pend      = bus.reg_we_i && (bus.reg_addr_i == IRQ_PEND);
    assign wr_mask      = bus.reg_we_i && (bus.reg_addr_i == IRQ_MASK);
    assign wr_mode      = bus.reg_we_i && (bus.reg_addr_i == IRQ_MODE);
    assign eoi          = bus.reg_we_i && (bus.reg_addr_i == IRQ_CTRL)
                          && bus.reg_wdata_i[CTRL_EOI_BIT];
    assign unused_wdata = ^bus.reg_wdata_i;

    assign active = pend_q & mask_q;

    // Fixed priority: lowest index wins, so scan downward and let the last hit stand
    always_comb begin
        sel_id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // PEND next value; edge-mode set beats a same-cycle W1C or Iack clear
    always_comb begin
        clr    = wr_pend ? wdata_src : '0;
        pend_d = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (ack_take && (id_q == ID_W'(i))) begin
                clr[i] = 1'b1;
            end
            pend_d[i] = mode_q[i] ? lvl[i] : (rise[i] | (pend_q[i] & ~clr[i]));
        end
    end

    // FSM next state, ID update and acknowledge qualification
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ack_take = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (active != '0) begin
                    state_d = IRQ_REQ;
                    id_d    = sel_id;
                end
            end
            IRQ_REQ: begin
                if (active == '0) begin
                    state_d = IRQ_IDLE;
                end else if (bus.Iack) begin
                    state_d  = IRQ_SVC;
                    ack_take = 1'b1;
                end else begin
                    id_d = sel_id;
                end
            end
            IRQ_SVC: begin
                if (eoi) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // FSM state register; Ireq registered from the next state so it moves with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IRQ_IDLE;
            id_q    <= '0;
            ireq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ireq_q  <= (state_d == IRQ_REQ);
        end
    end

    // PEND / MASK / MODE registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= wdata_src;
            end
            if (wr_mode) begin
                mode_q <= wdata_src;
            end
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        case (bus.reg_addr_i)
            IRQ_PEND: rdata[N_SRC-1:0] = pend_q;
            IRQ_MASK: rdata[N_SRC-1:0] = mask_q;
            IRQ_MODE: rdata[N_SRC-1:0] = mode_q;
            default: begin
                rdata[ID_W-1:0]                          = id_q;
                rdata[CTRL_STATE_LSB +: CTRL_STATE_W]    = state_q;
                rdata[CTRL_IREQ_BIT]                     = ireq_q;
            end
        endcase
    end

    assign bus.reg_rdata_o = rdata;
    assign bus.Ireq        = ireq_q;
    assign bus.irq_id_o    = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by a random
// phase, every cycle cross-checked against a behavioural reference model.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src = 8'h00;
    logic        we = 1'b0;
    logic        iack = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_if #(.ID_W(4)) bus ();

    assign bus.reg_we_i    = we;
    assign bus.reg_addr_i  = addr;
    assign bus.reg_wdata_i = wdata;
    assign bus.Iack        = iack;

    irq_ctrl #(.N_SRC(8), .ID_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src_i (src),
        .bus       (bus)
    );

    // Reference model state
    logic [7:0] m_pend = '0;
    logic [7:0] m_mask = '0;
    logic [7:0] m_mode = '0;
    logic [3:0] m_id   = '0;
    int         m_state = 0;      // 0 idle, 1 request, 2 service
    logic       m_ireq = 1'b0;
    logic [7:0] smp_last  = '0;   // sources as sampled at the previous edges
    logic [7:0] smp_prev  = '0;
    logic [7:0] smp_prev2 = '0;

    // Advance the model by one rising edge using the inputs applied before it
    task automatic m_edge();
        logic [7:0] lvl, rse, act, np;
        int sel, ns;
        logic [3:0] nid;
        bit ack, is_eoi, wr_p;
        if (!rst) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_id = '0;
            m_state = 0; m_ireq = 1'b0;
            smp_last = '0; smp_prev = '0; smp_prev2 = '0;
            return;
        end
        // synchronized level is the source as it stood two edges ago
        lvl = smp_prev;
        rse = smp_prev & ~smp_prev2;
        act = m_pend & m_mask;
        sel = 0;
        for (int i = 7; i >= 0; i--) if (act[i]) sel = i;
        wr_p   = we && (addr == IRQ_PEND);
        is_eoi = we && (addr == IRQ_CTRL) && wdata[0];
        ack    = (m_state == 1) && (act != 0) && iack;
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i])                                          np[i] = lvl[i];
            else if (rse[i])                                        np[i] = 1'b1;
            else if ((wr_p && wdata[i]) || (ack && int'(m_id) == i)) np[i] = 1'b0;
            else                                                    np[i] = m_pend[i];
        end
        ns  = m_state;
        nid = m_id;
        if (m_state == 0) begin
            if (act != 0) begin ns = 1; nid = 4'(sel); end
        end else if (m_state == 1) begin
            if (act == 0)  ns = 0;
            else if (iack) ns = 2;
            else           nid = 4'(sel);
        end else begin
            if (is_eoi) ns = 0;
        end
        if (we && addr == IRQ_MASK) m_mask = wdata[7:0];
        if (we && addr == IRQ_MODE) m_mode = wdata[7:0];
        m_pend    = np;
        m_state   = ns;
        m_id      = nid;
        m_ireq    = (ns == 1);
        smp_prev2 = smp_prev;
        smp_prev  = smp_last;
        smp_last  = src;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            IRQ_PEND: return {24'h0, m_pend};
            IRQ_MASK: return {24'h0, m_mask};
            IRQ_MODE: return {24'h0, m_mode};
            default:  return {m_ireq, 2'(m_state), 25'h0, m_id};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        check("ireq",   32'(bus.Ireq),     32'(m_ireq));
        check("irq_id", 32'(bus.irq_id_o), 32'(m_id));
        check("rdata",  bus.reg_rdata_o,   m_read(addr));
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        we = 1'b1; addr = a; wdata = v;
        cyc();
        we = 1'b0;
    endtask

    task automatic ack_once();
        iack = 1'b1;
        cyc();
        iack = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
        addr = a;
        #1;
        check(tag, bus.reg_rdata_o, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all sources high
        rst = 1'b0; src = 8'hFF;
        cycn(3);
        check("rst_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("rst_pend", IRQ_PEND, 32'h0);
        expect_reg("rst_ctrl", IRQ_CTRL, 32'h0);
        rst = 1'b1;
        cycn(5);
        check("rel_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("rel_pend", IRQ_PEND, 32'hFF);
        src = 8'h00;
        wr(IRQ_PEND, 32'hFF);
        expect_reg("w1c_all", IRQ_PEND, 32'h0);

        // Basic flow on source 3
        wr(IRQ_MASK, 32'hFF);
        src = 8'h08;
        cyc();
        cyc();
        src = 8'h00;
        cyc();
        check("bas_t2_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("bas_t2_pend", IRQ_PEND, 32'h08);
        cyc();
        check("bas_t3_ireq", 32'(bus.Ireq), 32'd1);
        check("bas_t3_id", 32'(bus.irq_id_o), 32'd3);
        ack_once();
        check("bas_ack_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("bas_ack_pend", IRQ_PEND, 32'h0);
        expect_reg("bas_ack_ctrl", IRQ_CTRL, 32'h40000003);
        cycn(2);
        wr(IRQ_CTRL, 32'h1);
        expect_reg("bas_eoi_ctrl", IRQ_CTRL, 32'h00000003);
        cyc();
        check("bas_post_ireq", 32'(bus.Ireq), 32'd0);

        // Priority: sources 5 and 2 together
        src = 8'h24;
        cycn(2);
        src = 8'h00;
        cycn(2);
        check("pri_ireq", 32'(bus.Ireq), 32'd1);
        check("pri_id", 32'(bus.irq_id_o), 32'd2);
        ack_once();
        wr(IRQ_CTRL, 32'h1);
        expect_reg("pri_eoi_ctrl", IRQ_CTRL, 32'h00000002);
        cyc();
        expect_reg("pri_next_ctrl", IRQ_CTRL, 32'hA0000005);
        ack_once();
        wr(IRQ_CTRL, 32'h1);
        cyc();
        check("pri_done_ireq", 32'(bus.Ireq), 32'd0);

        // Level mode on source 1
        wr(IRQ_MODE, 32'h02);
        src = 8'h02;
        cycn(4);
        check("lvl_ireq", 32'(bus.Ireq), 32'd1);
        check("lvl_id", 32'(bus.irq_id_o), 32'd1);
        ack_once();
        check("lvl_ack_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("lvl_ack_pend", IRQ_PEND, 32'h02);
        wr(IRQ_CTRL, 32'h1);
        cyc();
        check("lvl_reassert", 32'(bus.Ireq), 32'd1);
        src = 8'h00;
        cycn(2);
        expect_reg("lvl_drop_d1", IRQ_PEND, 32'h02);
        cyc();
        expect_reg("lvl_drop_d2", IRQ_PEND, 32'h00);
        cyc();
        expect_reg("lvl_idle_ctrl", IRQ_CTRL, 32'h00000001);
        wr(IRQ_MODE, 32'h0);

        // Same-cycle set and W1C on source 4: set wins
        src = 8'h10;
        cycn(2);
        src = 8'h00;
        wr(IRQ_PEND, 32'h10);
        expect_reg("setwin_pend", IRQ_PEND, 32'h10);
        cyc();
        check("setwin_id", 32'(bus.irq_id_o), 32'd4);
        // Mask removed during REQ
        wr(IRQ_MASK, 32'h0);
        check("mask_hold_ireq", 32'(bus.Ireq), 32'd1);
        cyc();
        check("mask_drop_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("mask_drop_ctrl", IRQ_CTRL, 32'h00000004);
        wr(IRQ_MASK, 32'hFF);
        cyc();
        check("remask_ireq", 32'(bus.Ireq), 32'd1);
        ack_once();
        // Iack while in SERVICE is ignored
        ack_once();
        expect_reg("svc_iack_ctrl", IRQ_CTRL, 32'h40000004);
        expect_reg("svc_iack_pend", IRQ_PEND, 32'h0);
        wr(IRQ_CTRL, 32'h1);
        cyc();

        // Reset in the middle of SERVICE with PEND=0x0A
        src = 8'h02;
        cycn(2);
        src = 8'h00;
        cycn(2);
        ack_once();
        src = 8'h0A;
        cycn(2);
        src = 8'h00;
        cyc();
        expect_reg("mid_pend", IRQ_PEND, 32'h0A);
        expect_reg("mid_ctrl", IRQ_CTRL, 32'h40000001);
        rst = 1'b0;
        cyc();
        check("mid_rst_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("mid_rst_pend", IRQ_PEND, 32'h0);
        expect_reg("mid_rst_mask", IRQ_MASK, 32'h0);
        expect_reg("mid_rst_ctrl", IRQ_CTRL, 32'h0);
        rst = 1'b1;
        src = 8'h04;
        cycn(2);
        src = 8'h00;
        cycn(4);
        check("post_rst_ireq", 32'(bus.Ireq), 32'd0);
        expect_reg("post_rst_pend", IRQ_PEND, 32'h04);
        wr(IRQ_MASK, 32'hFF);
        cyc();
        check("post_mask_ireq", 32'(bus.Ireq), 32'd1);
        check("post_mask_id", 32'(bus.irq_id_o), 32'd2);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int k;
            if ($urandom_range(0, 99) < 10) src = src ^ 8'(1 << $urandom_range(0, 7));
            we    = 1'b0;
            iack  = ($urandom_range(0, 7) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom();
            k = int'($urandom_range(0, 99));
            if (k < 4)       begin we = 1'b1; addr = IRQ_MASK; end
            else if (k < 8)  begin we = 1'b1; addr = IRQ_PEND; end
            else if (k < 10) begin we = 1'b1; addr = IRQ_MODE; end
            else if (k < 16) begin we = 1'b1; addr = IRQ_CTRL; end
            rst = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
